// File: rtl/keysw_io_device.sv
// Memory-mapped KEY/SW input peripheral: sync, debounce, sticky W1C press/change flags (optional IRQ: KEYDEV_IRQ_EN).
// Latency: DOUT/HIT combinational from ADDR; debounced level changes STABLE ticks + 2 cycles after input settles.
// Backpressure: none; bus accesses complete in one cycle, writes act on the CLK edge where WE && HIT.
module keysw_io_device #(
  parameter int                 DBITS    = 16,
  parameter logic [DBITS-1:0]   BASE     = 16'hFFF0,
  parameter int                 TICK_DIV = 50000,
  parameter int                 STABLE   = 3
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [DBITS-1:0] ADDR,
  input  logic [DBITS-1:0] DIN,
  input  logic             WE,
  output logic [DBITS-1:0] DOUT,
  output logic             HIT,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW
`ifdef KEYDEV_IRQ_EN
  ,
  output logic             IRQ
`endif
);

  localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [2:0]      CNT_LAST = 3'(STABLE - 1);
  // Keys idle high (released), switches idle low.
  localparam logic [13:0]     DEB_RST  = 14'h000F;

  localparam logic [1:0] SEL_KSTAT = 2'd2;
  localparam logic [1:0] SEL_SSTAT = 2'd3;

  // Bits [3:0] are KEY, bits [13:4] are SW throughout the input path.
  logic [13:0]      raw;
  logic [13:0]      sync1_q, sync2_q;
  logic [13:0]      deb_q, deb_d;
  logic [13:0][2:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;
  logic [4:0]       kstat_q, kstat_d;
  logic [9:0]       sstat_q, sstat_d;
  logic             ie_rd;

  logic             hit;
  logic [1:0]       reg_sel;
  logic             wr_kstat, wr_sstat;
  logic [4:0]       kclr;
  logic [9:0]       sclr;
  logic [3:0]       press;
  logic [9:0]       sw_chg;
  logic             ovr;

  assign raw = {SW, KEY};

  // Free-running prescaler; tick is high on the last count, i.e. on the wrap edge.
  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // Per-bit debounce: flip only after STABLE consecutive ticks of disagreement.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (tick) begin
      for (int i = 0; i < 14; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 3'd1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Address decode; ADDR[0] is ignored so byte and halfword addresses alias.
  always_comb begin
    hit      = (ADDR[DBITS-1:3] == BASE[DBITS-1:3]);
    reg_sel  = ADDR[2:1];
    wr_kstat = WE && hit && (reg_sel == SEL_KSTAT);
    wr_sstat = WE && hit && (reg_sel == SEL_SSTAT);
  end

  // Sticky flags: a set in the same cycle as its W1C wins, and such a press is not an overrun.
  always_comb begin
    kclr     = wr_kstat ? DIN[4:0] : 5'd0;
    sclr     = wr_sstat ? DIN[9:0] : 10'd0;
    press    = deb_q[3:0] & ~deb_d[3:0];
    sw_chg   = deb_q[13:4] ^ deb_d[13:4];
    ovr      = |(press & kstat_q[3:0] & ~kclr[3:0]);
    kstat_d  = {(kstat_q[4] & ~kclr[4]) | ovr, (kstat_q[3:0] & ~kclr[3:0]) | press};
    sstat_d  = (sstat_q & ~sclr) | sw_chg;
  end

  // Input path and status state.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      sync1_q <= DEB_RST;
      sync2_q <= DEB_RST;
      deb_q   <= DEB_RST;
      cnt_q   <= '0;
      pre_q   <= '0;
      kstat_q <= '0;
      sstat_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      kstat_q <= kstat_d;
      sstat_q <= sstat_d;
    end
  end

`ifdef KEYDEV_IRQ_EN
  logic ie_q, ie_d;
  logic irq_q, irq_d;
  logic unused_bus;

  // IE is a plain R/W bit in KSTAT; IRQ lags flag/IE changes by one cycle.
  always_comb begin
    ie_d  = wr_kstat ? DIN[8] : ie_q;
    irq_d = ie_q && (|kstat_q);
  end

  // Interrupt enable and registered interrupt output.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign ie_rd      = ie_q;
  assign IRQ        = irq_q;
  assign unused_bus = ^{DIN[DBITS-1:9], DIN[7:5], ADDR[0]};
`else
  logic unused_bus;
  assign ie_rd      = 1'b0;
  assign unused_bus = ^{DIN[DBITS-1:5], ADDR[0]};
`endif

  // Read mux: purely combinational, zero when the address misses the window.
  always_comb begin
    DOUT = '0;
    HIT  = hit;
    if (hit) begin
      case (reg_sel)
        2'd0:    DOUT[3:0] = deb_q[3:0];
        2'd1:    DOUT[9:0] = deb_q[13:4];
        2'd2:    begin
                   DOUT[4:0] = kstat_q;
                   DOUT[8]   = ie_rd;
                 end
        default: DOUT[9:0] = sstat_q;
      endcase
    end
  end

endmodule

// File: tb/tb_keysw_io_device.sv
module tb_keysw_io_device;

  localparam int TD = 4;
  localparam int ST = 3;

  logic        CLK;
  logic        RESET_N;
  logic [15:0] ADDR;
  logic [15:0] DIN;
  logic        WE;
  logic [15:0] DOUT;
  logic        HIT;
  logic [3:0]  KEY;
  logic [9:0]  SW;
`ifdef KEYDEV_IRQ_EN
  logic        IRQ;
`endif

  keysw_io_device #(
    .DBITS    (16),
    .BASE     (16'hFFF0),
    .TICK_DIV (TD),
    .STABLE   (ST)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .ADDR    (ADDR),
    .DIN     (DIN),
    .WE      (WE),
    .DOUT    (DOUT),
    .HIT     (HIT),
    .KEY     (KEY),
    .SW      (SW)
`ifdef KEYDEV_IRQ_EN
    ,
    .IRQ     (IRQ)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: input history, debounced levels, run lengths of disagreeing ticks, flags.
  logic [13:0] m_hist1, m_hist2;
  logic [13:0] m_deb;
  int          m_run [14];
  int          m_cyc;
  logic [4:0]  m_kst;
  logic [9:0]  m_sst;
  logic        m_ie;
  logic        m_irq;
  bit          m_valid = 0;

  function automatic logic model_hit(input logic [15:0] a);
    return (a >= 16'hFFF0) && (a <= 16'hFFF7);
  endfunction

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    logic [15:0] r;
    r = 16'h0000;
    if (model_hit(a)) begin
      if (a < 16'hFFF2)      r = {12'h000, m_deb[3:0]};
      else if (a < 16'hFFF4) r = {6'h00, m_deb[13:4]};
      else if (a < 16'hFFF6) r = {7'h00, m_ie, 3'b000, m_kst};
      else                   r = {6'h00, m_sst};
    end
    return r;
  endfunction

  // True when the coming edge registers a press of key b.
  function automatic bit press_coming(input int b);
    return (m_cyc % TD == TD - 1) && (m_hist2[b] != m_deb[b]) && (m_run[b] + 1 == ST) && m_deb[b];
  endfunction

  task automatic model_step();
    logic [13:0] nd;
    logic [3:0]  prs;
    logic [9:0]  chg;
    logic [4:0]  kc;
    logic [9:0]  sc;
    logic        wr;
    bit          ov;
    if (!RESET_N) begin
      m_hist1 = 14'h000F; m_hist2 = 14'h000F; m_deb = 14'h000F;
      foreach (m_run[i]) m_run[i] = 0;
      m_cyc = 0; m_kst = 0; m_sst = 0; m_ie = 0; m_irq = 0;
      m_valid = 1;
      return;
    end
    nd = m_deb;
    if (m_cyc % TD == TD - 1) begin
      for (int b = 0; b < 14; b++) begin
        if (m_hist2[b] != m_deb[b]) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == ST) begin
            nd[b] = m_hist2[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
    end
    m_cyc++;
    prs = m_deb[3:0] & ~nd[3:0];
    chg = m_deb[13:4] ^ nd[13:4];
    wr  = WE && model_hit(ADDR);
    kc  = (wr && ADDR[2:1] == 2'd2) ? DIN[4:0] : 5'd0;
    sc  = (wr && ADDR[2:1] == 2'd3) ? DIN[9:0] : 10'd0;
    ov  = 0;
    for (int i = 0; i < 4; i++) if (prs[i] && m_kst[i] && !kc[i]) ov = 1;
`ifdef KEYDEV_IRQ_EN
    m_irq = m_ie && (m_kst != 0);
    if (wr && ADDR[2:1] == 2'd2) m_ie = DIN[8];
`endif
    for (int i = 0; i < 4; i++) m_kst[i] = prs[i] ? 1'b1 : (kc[i] ? 1'b0 : m_kst[i]);
    m_kst[4] = ov ? 1'b1 : (kc[4] ? 1'b0 : m_kst[4]);
    for (int j = 0; j < 10; j++) m_sst[j] = chg[j] ? 1'b1 : (sc[j] ? 1'b0 : m_sst[j]);
    m_deb   = nd;
    m_hist2 = m_hist1;
    m_hist1 = {SW, KEY};
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model, then the DUT.
  task automatic step_x(input bit d_en, input logic [15:0] d_exp,
                        input bit h_en, input logic h_exp, input string tag);
    @(negedge CLK);
    if (m_valid) begin
      chk("hit", {31'd0, HIT}, {31'd0, model_hit(ADDR)});
      chk("dout", {16'd0, DOUT}, {16'd0, model_rd(ADDR)});
`ifdef KEYDEV_IRQ_EN
      chk("irq", {31'd0, IRQ}, {31'd0, m_irq});
`endif
    end
    if (d_en) chk(tag, {16'd0, DOUT}, {16'd0, d_exp});
    if (h_en) chk({tag, "_hit"}, {31'd0, HIT}, {31'd0, h_exp});
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic step();
    step_x(0, 16'h0, 0, 1'b0, "");
  endtask

  task automatic hold(input int n);
    WE = 0;
    repeat (n) step();
  endtask

  task automatic rdchk(input logic [15:0] a, input logic [15:0] e, input string tag);
    ADDR = a; WE = 0;
    step_x(1, e, 0, 1'b0, tag);
  endtask

  task automatic hitchk(input logic [15:0] a, input logic h, input string tag);
    ADDR = a; WE = 0;
    step_x(!h, 16'h0, 1, h, tag);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    ADDR = a; DIN = d; WE = 1;
    step();
    WE = 0;
  endtask

  initial begin
    bit found;
    RESET_N = 0; KEY = 4'hF; SW = 10'h000; ADDR = 16'hFFF0; DIN = 0; WE = 0;
    hold(3);
    RESET_N = 1;

    // Reset state and address window
    rdchk(16'hFFF0, 16'h000F, "rst_kdata");
    rdchk(16'hFFF2, 16'h0000, "rst_sdata");
    rdchk(16'hFFF4, 16'h0000, "rst_kstat");
    rdchk(16'hFFF6, 16'h0000, "rst_sstat");
    hitchk(16'hFFF1, 1'b1, "hit_fff1");
    hitchk(16'hFFF7, 1'b1, "hit_fff7");
    hitchk(16'hFFEE, 1'b0, "miss_ffee");
    hitchk(16'hFFF8, 1'b0, "miss_fff8");

    // A sub-tick glitch is rejected; a held press debounces and flags
    ADDR = 16'hFFF0;
    KEY = 4'hB; hold(3); KEY = 4'hF; hold(20);
    rdchk(16'hFFF0, 16'h000F, "glitch_kdata");
    KEY = 4'hB; hold(20);
    rdchk(16'hFFF0, 16'h000B, "press_kdata");
    rdchk(16'hFFF4, 16'h0004, "press_kstat");

    // Second press while flagged is an overrun; W1C clears both
    KEY = 4'hF; hold(20);
    rdchk(16'hFFF4, 16'h0004, "release_kstat");
    KEY = 4'hB; hold(20);
    rdchk(16'hFFF4, 16'h0014, "overrun_kstat");
    wr(16'hFFF4, 16'h0014);
    rdchk(16'hFFF4, 16'h0000, "w1c_kstat");

    // W1C landing on the same edge as a new press: set wins, no overrun
    KEY = 4'hA; hold(20);
    KEY = 4'hB; hold(20);
    KEY = 4'hA; ADDR = 16'hFFF4;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (press_coming(0)) begin
        found = 1;
        wr(16'hFFF4, 16'h0001);
      end else begin
        step();
      end
    end
    chk("w1c_set_found", {31'd0, found}, 32'd1);
    rdchk(16'hFFF4, 16'h0001, "w1c_set_kstat");

    // Switches: both directions flag, W1C per bit, data registers are read-only
    SW = 10'h3FF; hold(20);
    rdchk(16'hFFF2, 16'h03FF, "sw_sdata");
    rdchk(16'hFFF6, 16'h03FF, "sw_sstat");
    wr(16'hFFF6, 16'h0200);
    rdchk(16'hFFF6, 16'h01FF, "sw_w1c");
    wr(16'hFFF2, 16'hFFFF);
    rdchk(16'hFFF2, 16'h03FF, "sdata_ro");
    wr(16'hFFF0, 16'h0000);
    rdchk(16'hFFF0, 16'h000A, "kdata_ro");

    // IE bit and interrupt
    wr(16'hFFF4, 16'h001F);
    wr(16'hFFF4, 16'h0100);
`ifdef KEYDEV_IRQ_EN
    rdchk(16'hFFF4, 16'h0100, "ie_rd");
    KEY = 4'h8; hold(20);
    chk("irq_set", {31'd0, IRQ}, 32'd1);
    wr(16'hFFF4, 16'h0102);
    hold(2);
    chk("irq_clr", {31'd0, IRQ}, 32'd0);
`else
    rdchk(16'hFFF4, 16'h0000, "ie_absent");
`endif

    // Reset in the middle of debouncing
    KEY = 4'h0; SW = 10'h155; hold(7);
    RESET_N = 0; KEY = 4'hF; SW = 10'h000;
    step();
    RESET_N = 1;
    rdchk(16'hFFF0, 16'h000F, "mid_rst_kdata");
    rdchk(16'hFFF2, 16'h0000, "mid_rst_sdata");
    rdchk(16'hFFF4, 16'h0000, "mid_rst_kstat");
    rdchk(16'hFFF6, 16'h0000, "mid_rst_sstat");

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(24) == 0) KEY = 4'($urandom);
      if ($urandom_range(24) == 0) SW = 10'($urandom);
      case ($urandom_range(9))
        0:       ADDR = 16'hFFEE;
        1:       ADDR = 16'hFFF8;
        2:       ADDR = 16'($urandom);
        default: ADDR = 16'hFFF0 + 16'($urandom_range(7));
      endcase
      WE      = ($urandom_range(9) == 0);
      DIN     = 16'($urandom);
      RESET_N = ($urandom_range(599) != 0);
      step();
    end
    RESET_N = 1; WE = 0;
    hold(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
